// File: rtl/serial_subtractor_16_bit_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_16_bit_pkg
// Shared definitions for the nibble-serial 16-bit subtractor:
//   state_t      - controller states (IDLE, RUN, DONE)
//   WIDTH        - operand / result width
//   NIBBLE       - width of the slice processed per clock
//   NUM_NIBBLES  - number of slices per operation
// ----------------------------------------------------------------------------
package serial_subtractor_16_bit_pkg;

    localparam int WIDTH       = 16;
    localparam int NIBBLE      = 4;
    localparam int NUM_NIBBLES = WIDTH / NIBBLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_subtractor_16_bit_pkg

// File: rtl/full_subtractor_4_bit.sv
// ----------------------------------------------------------------------------
// full_subtractor_4_bit
// Purely combinational 4-bit subtractor: {Bout, Diff} = A - B - Bin.
// Ports:
//   A    [3:0] in  - minuend slice
//   B    [3:0] in  - subtrahend slice
//   Bin        in  - borrow in
//   Diff [3:0] out - difference slice
//   Bout       out - borrow out (1 when A < B + Bin, unsigned)
// ----------------------------------------------------------------------------
module full_subtractor_4_bit
    import serial_subtractor_16_bit_pkg::*;
(
    input  logic [NIBBLE-1:0] A,
    input  logic [NIBBLE-1:0] B,
    input  logic              Bin,
    output logic [NIBBLE-1:0] Diff,
    output logic              Bout
);

    logic [NIBBLE:0] w_res;

    // One extra bit catches the wrap: the MSB of the 5-bit difference is the
    // borrow out.
    assign w_res = {1'b0, A} - {1'b0, B} - {{NIBBLE{1'b0}}, Bin};
    assign Diff  = w_res[NIBBLE-1:0];
    assign Bout  = w_res[NIBBLE];

endmodule : full_subtractor_4_bit

// File: rtl/serial_subtractor_16_bit.sv
// ----------------------------------------------------------------------------
// serial_subtractor_16_bit
// Computes Diff = A - B - Bin (mod 2^16) one nibble per clock, reusing a
// single 4-bit subtractor. Also reports unsigned borrow-out and signed
// overflow.
// Ports:
//   Clk          in  - rising-edge clock
//   Reset        in  - synchronous active-high reset
//   Start        in  - request; sampled only while Ready=1
//   A, B  [15:0] in  - minuend / subtrahend, captured on accepted Start
//   Bin          in  - borrow in, captured on accepted Start
//   Ready        out - idle, able to accept Start
//   Done         out - one-cycle pulse, result valid
//   Diff  [15:0] out - difference (held until next accepted Start)
//   Bout         out - final borrow out
//   V            out - two's-complement overflow
// ----------------------------------------------------------------------------
module serial_subtractor_16_bit
    import serial_subtractor_16_bit_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V
);

    localparam logic [1:0] LAST_NIBBLE = 2'(NUM_NIBBLES - 1);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_borrow;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;
    logic              r_v;

    logic [3:0]        w_idx;
    logic [NIBBLE-1:0] w_a_nib;
    logic [NIBBLE-1:0] w_b_nib;
    logic [NIBBLE-1:0] w_diff_nib;
    logic              w_bout_nib;

    // Bit offset of the current nibble inside the operand words.
    assign w_idx   = {r_cnt, 2'b00};
    assign w_a_nib = r_a[w_idx +: NIBBLE];
    assign w_b_nib = r_b[w_idx +: NIBBLE];

    full_subtractor_4_bit u_fs (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Bin  (r_borrow),
        .Diff (w_diff_nib),
        .Bout (w_bout_nib)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_diff   <= '0;
                        r_bout   <= 1'b0;
                        r_v      <= 1'b0;
                        r_cnt    <= 2'd0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_diff[w_idx +: NIBBLE] <= w_diff_nib;
                    r_borrow                <= w_bout_nib;
                    r_cnt                   <= r_cnt + 2'd1;
                    if (r_cnt == LAST_NIBBLE) begin
                        r_bout  <= w_bout_nib;
                        // Result sign comes from the nibble being written this
                        // edge, not from the not-yet-updated register.
                        r_v     <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_diff_nib[NIBBLE-1] != r_a[WIDTH-1]);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Ready = (r_state == IDLE);
    assign Done  = (r_state == DONE);
    assign Diff  = r_diff;
    assign Bout  = r_bout;
    assign V     = r_v;

endmodule : serial_subtractor_16_bit

// File: tb/tb_serial_subtractor_16_bit.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor_16_bit
// Directed bench for serial_subtractor_16_bit. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_serial_subtractor_16_bit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        Ready;
    logic        Done;
    logic [15:0] Diff;
    logic        Bout;
    logic        V;

    int n_pass  = 0;
    int n_total = 0;

    serial_subtractor_16_bit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Ready (Ready),
        .Done  (Done),
        .Diff  (Diff),
        .Bout  (Bout),
        .V     (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Launch one operation and follow it edge by edge. Accept edge is e0;
    // nibble k is written at edge e(k+1); Done is high after e4; Ready after e5.
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [15:0] exp_diff, input logic exp_bout, input logic exp_v);
        logic [15:0] mask;
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(negedge Clk);                         // after e0
        Start = 1'b0;
        A = ~a; B = ~b; Bin = ~bin;             // must not affect the operation
        check({tag, "_ready_low"}, 32'(Ready), 32'd0);
        check({tag, "_diff_cleared"}, 32'(Diff), 32'd0);
        mask = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);                     // after e1..e3
            mask = {mask[11:0], 4'h0} | 16'h000F;
            mask = (k == 0) ? 16'h000F : (k == 1) ? 16'h00FF : 16'h0FFF;
            check({tag, "_done_early"}, 32'(Done), 32'd0);
            check({tag, "_partial"}, 32'(Diff), 32'(exp_diff & mask));
        end
        @(negedge Clk);                         // after e4
        check({tag, "_done"}, 32'(Done), 32'd1);
        check({tag, "_ready_in_done"}, 32'(Ready), 32'd0);
        check({tag, "_diff"}, 32'(Diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(Bout), 32'(exp_bout));
        check({tag, "_v"}, 32'(V), 32'(exp_v));
        @(negedge Clk);                         // after e5
        check({tag, "_ready_back"}, 32'(Ready), 32'd1);
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_diff_hold"}, 32'(Diff), 32'(exp_diff));
        check({tag, "_bout_hold"}, 32'(Bout), 32'(exp_bout));
    endtask

    int done_cnt;
    int done_at [2];

    initial begin
        Reset = 1'b1; Start = 1'b0; A = 16'h0; B = 16'h0; Bin = 1'b0;
        @(negedge Clk);
        Start = 1'b1;                           // reset must win over Start
        @(negedge Clk);
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_v", 32'(V), 32'd0);
        Start = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        check("idle_ready", 32'(Ready), 32'd1);

        run_op("v1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("vzero", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("vovf",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("vbin",  16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("vovf2", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("vall",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Start re-pulsed during RUN with different operands is ignored.
        A = 16'h1234; B = 16'h0234; Bin = 1'b0; Start = 1'b1;
        @(negedge Clk);                         // after e0
        Start = 1'b0;
        @(negedge Clk);                         // after e1
        A = 16'hFFFF; B = 16'h0001; Bin = 1'b1; Start = 1'b1;
        @(negedge Clk);                         // after e2
        Start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (Done) begin
                done_cnt++;
                check("ign_diff", 32'(Diff), 32'h1000);
                check("ign_bout", 32'(Bout), 32'd0);
            end
            @(negedge Clk);
        end
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_ready", 32'(Ready), 32'd1);

        // Reset in the second RUN cycle aborts the operation.
        A = 16'h0000; B = 16'h0001; Bin = 1'b0; Start = 1'b1;
        @(negedge Clk);                         // after e0
        Start = 1'b0;
        @(negedge Clk);                         // after e1
        check("abort_partial", 32'(Diff), 32'h000F);
        Reset = 1'b1;
        @(negedge Clk);                         // after e2 (reset)
        Reset = 1'b0;
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_bout", 32'(Bout), 32'd0);
        check("abort_v", 32'(V), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Start held high for 12 cycles: results every 6 cycles.
        A = 16'hFFFF; B = 16'hFFFF; Bin = 1'b0; Start = 1'b1;
        done_cnt = 0; done_at[0] = -1; done_at[1] = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (Done) begin
                if (done_cnt < 2) done_at[done_cnt] = i;
                done_cnt++;
                check("b2b_diff", 32'(Diff), 32'h0000);
                check("b2b_bout", 32'(Bout), 32'd0);
            end
        end
        Start = 1'b0;
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_first_at", 32'(done_at[0]), 32'd5);
        check("b2b_spacing", 32'(done_at[1] - done_at[0]), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_subtractor_16_bit

// File: doc/serial_subtractor_16_bit.md
SERIAL_SUBTRACTOR_16_BIT -- requirements
Module: serial_subtractor_16_bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port Clk SHALL be an input, 1 bit wide, and is the rising-edge clock for all state.
REQ-003 The port Reset SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-004 The port Start SHALL be an input, 1 bit wide, and requests an operation; it is sampled only while Ready=1.
REQ-005 The ports A and B SHALL each be inputs, 16 bits wide: A is the minuend and B is the subtrahend, both sampled when Start is accepted.
REQ-006 The port Bin SHALL be an input, 1 bit wide, and is the borrow-in, sampled when Start is accepted.
REQ-007 The port Ready SHALL be an output, 1 bit wide, and is high when the block is idle and able to accept Start.
REQ-008 The port Done SHALL be an output, 1 bit wide, and pulses high for one cycle when the result is valid.
REQ-009 The port Diff SHALL be an output, 16 bits wide, and carries the result A - B - Bin modulo 2^16.
REQ-010 The port Bout SHALL be an output, 1 bit wide, and is the final borrow-out (1 when A < B + Bin, unsigned).
REQ-011 The port V SHALL be an output, 1 bit wide, and is the two's-complement overflow flag of the subtraction.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with a 2-bit nibble counter.
REQ-013 IDLE: Ready=1; Start=1 at a clock edge SHALL latch A, B and Bin into operand registers, load the borrow register with Bin, clear Diff, Bout and V to 0, set the counter to 0, and move to RUN.
REQ-014 RUN: each edge SHALL compute nibble k = counter, i.e. Diff[4k+3:4k] = A_r[4k+3:4k] - B_r[4k+3:4k] - borrow; the nibble's borrow-out SHALL be stored in the borrow register and the counter SHALL increment.
REQ-015 RUN with counter=3: on that edge the block SHALL write the last nibble, set Bout to the final borrow and V = (A_r[15] != B_r[15]) && (Diff[15] != A_r[15]), and move to DONE.
REQ-016 DONE SHALL assert Done=1 for exactly one cycle, then move to IDLE.
REQ-017 Latency: if Start is accepted at edge e0, Done SHALL be high in the cycle after edge e4, and Ready SHALL return to 1 in the cycle after edge e5.
REQ-018 Ready SHALL be 0 in RUN and DONE, and Start SHALL be ignored in those states (no relatch, no restart).
REQ-019 Diff, Bout and V SHALL hold their values from DONE until the next accepted Start; Diff nibbles not yet computed read 0 during RUN.
REQ-020 Back-to-back: Start held high continuously SHALL begin a new operation on the first IDLE edge, giving one result every 6 cycles.
REQ-021 Changes on A, B and Bin after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-022 Reset=1 at an edge SHALL force IDLE from any state and abort any operation in flight.
REQ-023 Reset values SHALL be: Ready=1, Done=0, Diff=16'h0000, Bout=0, V=0, counter=0, borrow register=0, operand registers=0.
REQ-024 Reset SHALL have priority over Start at the same edge.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the constant WIDTH=16, NIBBLE=4 and NUM_NIBBLES=4.
REQ-026 One combinational sub-module, full_subtractor_4_bit (ports A, B, Bin, Diff, Bout), SHALL be instantiated once and reused every cycle via operand muxing.

Verification
REQ-027 A=16'h1234, B=16'h0234, Bin=0 -> Diff=16'h1000, Bout=0, V=0, with Done exactly 5 cycles after Start acceptance.
REQ-028 A=16'h0000, B=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1, V=0.
REQ-029 A=16'h8000, B=16'h0001, Bin=0 -> Diff=16'h7FFF, Bout=0, V=1; and A=16'h0005, B=16'h0003, Bin=1 -> Diff=16'h0001, Bout=0.
REQ-030 Start pulsed again during RUN with different operands -> those operands are ignored, the first result is unchanged, and exactly one Done pulse occurs.
REQ-031 Reset asserted in the second RUN cycle -> the next cycle shows Ready=1, Diff=0, Bout=0, V=0, Done=0, and no Done pulse follows.
REQ-032 Start held high for 12 cycles with A=16'hFFFF, B=16'hFFFF -> two Done pulses 6 cycles apart, each with Diff=16'h0000, Bout=0.
